// File: rtl/hls_phi_add_stage.sv
// Phi/branch/add datapath slice: selects a phi operand by the last block left,
// adds an addend to it, and registers the sum with a valid flag.
module hls_phi_add_stage #(
    parameter int WIDTH    = 32,
    parameter int NB_PAIR  = 2,
    parameter int BB_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NB_PAIR*WIDTH-1:0]    phi_in,
    input  logic [NB_PAIR*BB_WIDTH-1:0] phi_s,
    input  logic                        br_en,
    input  logic [BB_WIDTH-1:0]         br_src,
    input  logic [WIDTH-1:0]            addend,
    input  logic                        en,
    output logic [BB_WIDTH-1:0]         last_block,
    output logic [WIDTH-1:0]            phi_out,
    output logic [WIDTH-1:0]            sum,
    output logic [WIDTH-1:0]            res_q,
    output logic                        res_valid
);

    logic [BB_WIDTH-1:0] last_block_q;
    logic [BB_WIDTH-1:0] last_block_d;
    logic [WIDTH-1:0]    res_d;
    logic                res_valid_q;
    logic                res_valid_d;
    logic [WIDTH-1:0]    phi_out_s;
    logic [WIDTH-1:0]    sum_s;
    logic                found_s;

    // Phi select: the lowest-indexed pair whose block ID matches wins; no match gives zero.
    always_comb begin
        phi_out_s = {WIDTH{1'b0}};
        found_s   = 1'b0;
        for (int k = 0; k < NB_PAIR; k++) begin
            if (!found_s && (phi_s[k*BB_WIDTH +: BB_WIDTH] == last_block_q)) begin
                phi_out_s = phi_in[k*WIDTH +: WIDTH];
                found_s   = 1'b1;
            end else begin
                phi_out_s = phi_out_s;
                found_s   = found_s;
            end
        end
    end

    // Modular adder; the carry out is intentionally dropped.
    always_comb begin
        sum_s = phi_out_s + addend;
    end

    // Next-state for branch tracking and the result register.
    always_comb begin
        if (br_en) begin
            last_block_d = br_src;
        end else begin
            last_block_d = last_block_q;
        end
        if (en) begin
            res_d       = sum_s;
            res_valid_d = 1'b1;
        end else begin
            res_d       = res_q;
            res_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_block_q <= {BB_WIDTH{1'b0}};
            res_q        <= {WIDTH{1'b0}};
            res_valid_q  <= 1'b0;
        end else begin
            last_block_q <= last_block_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign last_block = last_block_q;
    assign res_valid  = res_valid_q;
    assign phi_out    = phi_out_s;
    assign sum        = sum_s;

endmodule

// File: tb/tb_hls_phi_add_stage.sv
// Directed self-checking bench for hls_phi_add_stage at WIDTH=8, NB_PAIR=2, BB_WIDTH=32.
module tb_hls_phi_add_stage;

    localparam int W  = 8;
    localparam int NP = 2;
    localparam int BW = 32;

    logic              clk;
    logic              rst;
    logic [NP*W-1:0]   phi_in;
    logic [NP*BW-1:0]  phi_s;
    logic              br_en;
    logic [BW-1:0]     br_src;
    logic [W-1:0]      addend;
    logic              en;
    logic [BW-1:0]     last_block;
    logic [W-1:0]      phi_out;
    logic [W-1:0]      sum;
    logic [W-1:0]      res_q;
    logic              res_valid;

    int checks;
    int failures;

    hls_phi_add_stage #(.WIDTH(W), .NB_PAIR(NP), .BB_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .phi_in(phi_in), .phi_s(phi_s),
        .br_en(br_en), .br_src(br_src), .addend(addend), .en(en),
        .last_block(last_block), .phi_out(phi_out), .sum(sum),
        .res_q(res_q), .res_valid(res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (last_block !== 32'd0) begin failures++; $display("FAIL reset_last_block got=%0d exp=0", last_block); end
        checks++; if (res_q !== 8'h00) begin failures++; $display("FAIL reset_res_q got=%0h exp=0", res_q); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
        checks++; if (phi_out !== 8'h00) begin failures++; $display("FAIL reset_phi_out got=%0h exp=0", phi_out); end
        checks++; if (sum !== 8'h01) begin failures++; $display("FAIL reset_sum got=%0h exp=1", sum); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_branch_select();
        br_en = 1'b1; br_src = 32'd1;
        #1;
        checks++; if (phi_out !== 8'h00) begin failures++; $display("FAIL branch_same_cycle phi_out got=%0h exp=0", phi_out); end
        tick();
        br_en = 1'b0;
        #1;
        checks++; if (last_block !== 32'd1) begin failures++; $display("FAIL branch_last_block got=%0d exp=1", last_block); end
        checks++; if (phi_out !== 8'h05) begin failures++; $display("FAIL branch_phi_out got=%0h exp=5", phi_out); end
        checks++; if (sum !== 8'h06) begin failures++; $display("FAIL branch_sum got=%0h exp=6", sum); end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (res_q !== 8'h06) begin failures++; $display("FAIL capture_res_q got=%0h exp=6", res_q); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL capture_res_valid got=%0b exp=1", res_valid); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL valid_drop got=%0b exp=0", res_valid); end
        checks++; if (res_q !== 8'h06) begin failures++; $display("FAIL hold_res_q got=%0h exp=6", res_q); end
    endtask

    task automatic test_wrap();
        phi_in = {8'hFF, 8'h00};
        #1;
        checks++; if (phi_out !== 8'hFF) begin failures++; $display("FAIL wrap_phi_out got=%0h exp=ff", phi_out); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL wrap_sum got=%0h exp=0", sum); end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (res_q !== 8'h00) begin failures++; $display("FAIL wrap_res_q got=%0h exp=0", res_q); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL wrap_res_valid got=%0b exp=1", res_valid); end
        phi_in = {8'h05, 8'h00};
    endtask

    task automatic test_no_match_priority();
        br_en = 1'b1; br_src = 32'd7;
        tick();
        br_en = 1'b0;
        #1;
        checks++; if (last_block !== 32'd7) begin failures++; $display("FAIL nomatch_last_block got=%0d exp=7", last_block); end
        checks++; if (phi_out !== 8'h00) begin failures++; $display("FAIL nomatch_phi_out got=%0h exp=0", phi_out); end
        checks++; if (sum !== 8'h01) begin failures++; $display("FAIL nomatch_sum got=%0h exp=1", sum); end
        phi_s = {32'd3, 32'd3};
        br_en = 1'b1; br_src = 32'd3;
        tick();
        br_en = 1'b0;
        #1;
        checks++; if (phi_out !== 8'h00) begin failures++; $display("FAIL priority_phi_out got=%0h exp=0", phi_out); end
        phi_in = {8'h05, 8'h09};
        #1;
        checks++; if (phi_out !== 8'h09) begin failures++; $display("FAIL priority2_phi_out got=%0h exp=9", phi_out); end
        phi_in = {8'h05, 8'h00};
        phi_s  = {32'd1, 32'd0};
    endtask

    task automatic test_simultaneous();
        br_en = 1'b1; br_src = 32'd0;
        tick();
        br_en = 1'b0;
        #1;
        checks++; if (sum !== 8'h01) begin failures++; $display("FAIL simul_pre_sum got=%0h exp=1", sum); end
        br_en = 1'b1; br_src = 32'd1; en = 1'b1;
        tick();
        br_en = 1'b0; en = 1'b0;
        #1;
        checks++; if (res_q !== 8'h01) begin failures++; $display("FAIL simul_res_q got=%0h exp=1", res_q); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL simul_res_valid got=%0b exp=1", res_valid); end
        checks++; if (last_block !== 32'd1) begin failures++; $display("FAIL simul_last_block got=%0d exp=1", last_block); end
        checks++; if (sum !== 8'h06) begin failures++; $display("FAIL simul_post_sum got=%0h exp=6", sum); end
    endtask

    task automatic test_reset_mid();
        #1;
        rst = 1'b0;
        #1;
        checks++; if (last_block !== 32'd0) begin failures++; $display("FAIL midrst_last_block got=%0d exp=0", last_block); end
        checks++; if (res_q !== 8'h00) begin failures++; $display("FAIL midrst_res_q got=%0h exp=0", res_q); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL midrst_res_valid got=%0b exp=0", res_valid); end
        checks++; if (sum !== 8'h01) begin failures++; $display("FAIL midrst_sum got=%0h exp=1", sum); end
        en = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_held_valid got=%0b exp=0", res_valid); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (res_q !== 8'h01) begin failures++; $display("FAIL post_rst_res_q got=%0h exp=1", res_q); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL post_rst_res_valid got=%0b exp=1", res_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        phi_in   = {8'h05, 8'h00};
        phi_s    = {32'd1, 32'd0};
        br_en    = 1'b0;
        br_src   = 32'd0;
        addend   = 8'h01;
        en       = 1'b0;
        test_reset();
        test_branch_select();
        test_wrap();
        test_no_match_priority();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
